// File: rtl/demux_1to16_deser_if.sv
// Bus bundle for the 1-to-16 deserializer: serial input handshake, word output
// handshake and the select/busy status seen by the consumer side.
interface demux_1to16_deser_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
);
  // Handshake: an input beat happens on a rising edge where in_valid && in_ready;
  // a word is taken on a rising edge where out_valid && out_ready. Neither ready
  // depends combinationally on the valid it is paired with, and a producer must
  // hold its data stable while valid is high and ready is low.
  logic             in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic             busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel, busy
  );
endinterface

// File: rtl/demux_1to16_deser.sv
// Serial-to-parallel deserializer: one bit per beat into a select-counter slot,
// completed words handed to a double-buffered output. Optional DEMUX_CLEAR_EN adds clear_i.
module demux_1to16_deser #(
  parameter int WIDTH     = 16,
  parameter int SEL_W     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
`ifdef DEMUX_CLEAR_EN
  input  logic               clear_i,
`endif
  demux_1to16_deser_if.slave bus,
  output logic               state_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(WIDTH - 1);

  state_e           state_q;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] slot;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             last;
  logic             beat;
  logic             complete;
  logic             clear;

`ifdef DEMUX_CLEAR_EN
  assign clear = clear_i;
`else
  assign clear = 1'b0;
`endif

  assign last     = (sel_q == LAST_SEL);
  // Only the final beat can stall, and only while the held word is still unconsumed.
  assign bus.in_ready = !(last && out_valid_q && !bus.out_ready);
  assign beat     = bus.in_valid && bus.in_ready;
  assign complete = beat && last && !clear;
  assign slot     = MSB_FIRST ? (LAST_SEL - sel_q) : sel_q;

  always_comb begin
    asm_d       = asm_q;
    asm_d[slot] = bus.in_data;
    sel_d       = last ? '0 : (sel_q + SEL_W'(1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sel_q <= '0;
      asm_q <= '0;
    end else if (clear) begin
      sel_q <= '0;
      asm_q <= '0;
    end else if (beat) begin
      sel_q <= sel_d;
      asm_q <= asm_d;
    end
  end

  // Output FSM: a completing word may replace a word consumed on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (complete) begin
            state_q     <= FULL;
            out_q       <= asm_d;
            out_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (complete) begin
            out_q <= asm_d;
          end else if (bus.out_ready) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = (sel_q != '0);
  assign state_o       = (state_q == FULL);

endmodule

// File: tb/tb_demux_1to16_deser.sv
// Scoreboard bench: an LSB-first and an MSB-first instance share one serial stream;
// expected words come from a queue of accepted bits packed with plain arithmetic.
module tb_demux_1to16_deser;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_data = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic clear = 1'b0;
  logic state_l, state_m;
  bit   rand_rdy = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_l_q[$];
  logic [W-1:0] exp_m_q[$];
  logic         bq[$];

  always #5 clk = ~clk;

  demux_1to16_deser_if #(.WIDTH(W), .SEL_W(4)) bus_l ();
  demux_1to16_deser_if #(.WIDTH(W), .SEL_W(4)) bus_m ();

  assign bus_l.in_data   = in_data;
  assign bus_l.in_valid  = in_valid;
  assign bus_l.out_ready = out_ready;
  assign bus_m.in_data   = in_data;
  assign bus_m.in_valid  = in_valid;
  assign bus_m.out_ready = out_ready;

  demux_1to16_deser #(.WIDTH(W), .SEL_W(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i   (clk),
    .rst_ni  (rst_n),
`ifdef DEMUX_CLEAR_EN
    .clear_i (clear),
`endif
    .bus     (bus_l),
    .state_o (state_l)
  );

  demux_1to16_deser #(.WIDTH(W), .SEL_W(4), .MSB_FIRST(1'b1)) u_msb (
    .clk_i   (clk),
    .rst_ni  (rst_n),
`ifdef DEMUX_CLEAR_EN
    .clear_i (clear),
`endif
    .bus     (bus_m),
    .state_o (state_m)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the k-th accepted bit of a word is bit k (LSB-first) or bit W-1-k (MSB-first).
  task automatic record_beat(input logic b, output bit done);
    logic [W-1:0] lw, mw;
    done = 1'b0;
    bq.push_back(b);
    if (bq.size() == W) begin
      lw = '0;
      mw = '0;
      for (int i = 0; i < W; i++) begin
        lw = lw | (16'(bq[i]) << i);
        mw = mw | (16'(bq[i]) << (W - 1 - i));
      end
      exp_l_q.push_back(lw);
      exp_m_q.push_back(mw);
      bq.delete();
      done = 1'b1;
    end
  endtask

  task automatic push_bit(input logic b, input int gap);
    int guard;
    bit done;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    chk("sel_l", 32'(bus_l.sel), 32'(bq.size()));
    chk("sel_m", 32'(bus_m.sel), 32'(bq.size()));
    chk("busy_l", 32'(bus_l.busy), 32'(bq.size() != 0));
    if (bq.size() != W - 1) chk("ready_early", 32'(bus_l.in_ready), 32'd1);
    guard = 0;
    while (!bus_l.in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=in_ready_low required=accept_within_500 at %0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    record_beat(b, done);
    if (done) begin
      chk("lat_l", 32'(bus_l.out_valid), 32'd1);
      chk("lat_m", 32'(bus_m.out_valid), 32'd1);
      chk("sel_wrap", 32'(bus_l.sel), 32'd0);
      chk("busy_wrap", 32'(bus_m.busy), 32'd0);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit msb_order, input int gmin, input int gmax);
    for (int i = 0; i < W; i++) begin
      push_bit(msb_order ? w[W-1-i] : w[i], $urandom_range(gmin, gmax));
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Out_ready randomiser, active only during the random phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops on every consumed word; checks a held word stays stable.
  initial begin
    logic [W-1:0] prev_l, prev_m, e;
    bit prev_hold;
    prev_l = '0;
    prev_m = '0;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && bus_l.out_valid) begin
          chk("hold_l", 32'(bus_l.out_data), 32'(prev_l));
          chk("hold_m", 32'(bus_m.out_data), 32'(prev_m));
        end
        if (bus_l.out_valid && out_ready) begin
          if (exp_l_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_l actual=%0h required=no_word at %0t", bus_l.out_data, $time);
          end else begin
            e = exp_l_q.pop_front();
            chk("word_l", 32'(bus_l.out_data), 32'(e));
          end
        end
        if (bus_m.out_valid && out_ready) begin
          if (exp_m_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_m actual=%0h required=no_word at %0t", bus_m.out_data, $time);
          end else begin
            e = exp_m_q.pop_front();
            chk("word_m", 32'(bus_m.out_data), 32'(e));
          end
        end
        prev_hold = bus_l.out_valid && !out_ready;
        prev_l = bus_l.out_data;
        prev_m = bus_m.out_data;
      end
    end
  end

  initial begin
    logic [W-1:0] w, w1;
    int guard;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_l", 32'(bus_l.out_data), 32'd0);
    chk("rst_out_m", 32'(bus_m.out_data), 32'd0);
    chk("rst_valid", 32'(bus_l.out_valid), 32'd0);
    chk("rst_sel", 32'(bus_l.sel), 32'd0);
    chk("rst_busy", 32'(bus_l.busy), 32'd0);
    chk("rst_ready", 32'(bus_l.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic back-to-back assembly of bit i = i%2
    out_ready = 1'b1;
    send_word(16'hAAAA, 1'b0, 0, 0);
    settle();

    // Gapped input, one idle cycle before every beat
    send_word(16'hAAAA, 1'b0, 1, 1);
    settle();

    // Backpressure on the final beat
    out_ready = 1'b0;
    send_word(16'hF0F0, 1'b0, 0, 0);
    w = 16'h1234;
    for (int i = 0; i < W - 1; i++) push_bit(w[i], 0);
    in_data  = w[W-1];
    in_valid = 1'b1;
    @(negedge clk);
    chk("stall_ready", 32'(bus_l.in_ready), 32'd0);
    chk("stall_sel", 32'(bus_l.sel), 32'd15);
    chk("stall_out", 32'(bus_l.out_data), 32'hF0F0);
    repeat (3) @(negedge clk);
    chk("stall_out2", 32'(bus_l.out_data), 32'hF0F0);
    chk("stall_ready2", 32'(bus_m.in_ready), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_bit(w[W-1], 0);
    @(negedge clk);
    chk("bp_out", 32'(bus_l.out_data), 32'h1234);
    settle();

    // Consume and complete on the same edge
    out_ready = 1'b0;
    w1 = 16'($urandom);
    send_word(w1, 1'b0, 0, 0);
    w = 16'($urandom);
    for (int i = 0; i < W - 1; i++) push_bit(w[i], 0);
    out_ready = 1'b1;
    push_bit(w[W-1], 0);
    @(negedge clk);
    chk("nobubble_valid", 32'(bus_l.out_valid), 32'd1);
    chk("nobubble_out", 32'(bus_l.out_data), 32'(w));
    settle();

    // Asynchronous reset mid-word
    for (int i = 0; i < 7; i++) push_bit(1'($urandom_range(0, 1)), 0);
    #2;
    rst_n = 1'b0;
    exp_l_q.delete();
    exp_m_q.delete();
    bq.delete();
    #1;
    chk("arst_sel", 32'(bus_l.sel), 32'd0);
    chk("arst_busy", 32'(bus_l.busy), 32'd0);
    chk("arst_valid", 32'(bus_l.out_valid), 32'd0);
    chk("arst_out", 32'(bus_m.out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_word(16'h5555, 1'b0, 0, 0);
    settle();

`ifdef DEMUX_CLEAR_EN
    // Clear discards a partial word, then an MSB-first frame
    for (int i = 0; i < 5; i++) push_bit(1'($urandom_range(0, 1)), 0);
    in_data  = 1'b1;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    chk("clr_ready", 32'(bus_l.in_ready), 32'd1);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    bq.delete();
    chk("clr_sel_l", 32'(bus_l.sel), 32'd0);
    chk("clr_sel_m", 32'(bus_m.sel), 32'd0);
    send_word(16'hC3A5, 1'b1, 0, 0);
    settle();
`endif

    // Randomised words, gaps and consumer backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 12; n++) begin
      send_word(16'($urandom), 1'($urandom_range(0, 1)), 0, 2);
    end
    @(posedge clk); #2;
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((exp_l_q.size() != 0 || exp_m_q.size() != 0) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_l", 32'(exp_l_q.size()), 32'd0);
    chk("drain_m", 32'(exp_m_q.size()), 32'd0);
    @(negedge clk);
    chk("idle_valid", 32'(bus_l.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
